// File: rtl/sm4_key_sched_rev.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm4_key_sched_rev : iterative SM4 key expansion, 32-entry round-key store |
// | with forward/reverse read port.                     Revision: 1.0         |
// +--------------------------------------------------------------------------+

module sm4_sbox (
    input  logic [7:0] din_i,
    output logic [7:0] dout_o
);
    localparam logic [127:0] c_ROW [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic [127:0] w_row;

    assign w_row  = c_ROW[din_i[7:4]];
    // Column 0 sits in the top byte of each row word.
    assign dout_o = 8'(w_row >> {~din_i[3:0], 3'b000});
endmodule

module sm4_key_sched_rev #(
    parameter int WIDTH  = 32,
    parameter int NROUND = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic [4*WIDTH-1:0]   key,
    output logic                 key_ready,
    output logic                 busy,
    output logic                 keys_valid,
    input  logic                 rd_en,
    input  logic [4:0]           rd_idx,
    input  logic                 dec,
    output logic [WIDTH-1:0]     rk_out,
    output logic                 rk_valid
);
    localparam logic [WIDTH-1:0] c_FK0 = 32'hA3B1BAC6;
    localparam logic [WIDTH-1:0] c_FK1 = 32'h56AA3350;
    localparam logic [WIDTH-1:0] c_FK2 = 32'h677D9197;
    localparam logic [WIDTH-1:0] c_FK3 = 32'hB27022DC;
    localparam logic [4:0]       c_LAST = 5'(NROUND - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] k_q [4];
    logic [4:0]       cnt_q;
    logic             key_ready_q;
    logic             busy_q;
    logic             keys_valid_q;
    logic [WIDTH-1:0] rk_out_q;
    logic             rk_valid_q;
    logic [WIDTH-1:0] store_q [NROUND];

    logic [7:0]       w_base;
    logic [WIDTH-1:0] w_ck;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_rk;
    logic [4:0]       w_rd_addr;

    assign w_base = {1'b0, cnt_q, 2'b00};

    generate
        for (genvar j = 0; j < 4; j++) begin : g_byte
            localparam logic [7:0] c_J = 8'(j);
            // CK byte j of round i is ((4i+j)*7) mod 256; the 8-bit product wraps for free.
            assign w_ck[WIDTH-1-8*j -: 8] = (w_base + c_J) * 8'd7;

            sm4_sbox u_sbox (
                .din_i  (w_a[WIDTH-1-8*j -: 8]),
                .dout_o (w_b[WIDTH-1-8*j -: 8])
            );
        end
    endgenerate

    assign w_a  = k_q[1] ^ k_q[2] ^ k_q[3] ^ w_ck;
    assign w_c  = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
    assign w_rk = k_q[0] ^ w_c;

    assign w_rd_addr = dec ? (c_LAST - rd_idx) : rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            cnt_q        <= '0;
            rk_out_q     <= '0;
            rk_valid_q   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                k_q[n] <= '0;
            end
        end else begin
            // The read uses keys_valid as it was before this edge, so a
            // same-edge re-key still serves the old table.
            rk_valid_q <= rd_en && keys_valid_q;
            if (rd_en && keys_valid_q) begin
                rk_out_q <= store_q[w_rd_addr];
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (key_valid && key_ready_q) begin
                        k_q[0]       <= key[4*WIDTH-1:3*WIDTH] ^ c_FK0;
                        k_q[1]       <= key[3*WIDTH-1:2*WIDTH] ^ c_FK1;
                        k_q[2]       <= key[2*WIDTH-1:WIDTH]   ^ c_FK2;
                        k_q[3]       <= key[WIDTH-1:0]         ^ c_FK3;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        key_ready_q  <= 1'b0;
                        keys_valid_q <= 1'b0;
                        state_q      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    k_q[0] <= k_q[1];
                    k_q[1] <= k_q[2];
                    k_q[2] <= k_q[3];
                    k_q[3] <= w_rk;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == c_LAST) begin
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                        key_ready_q  <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_EXPAND) begin
            store_q[cnt_q] <= w_rk;
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rk_out     = rk_out_q;
    assign rk_valid   = rk_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_sm4_key_sched_rev.sv
`default_nettype none
// Self-checking bench for sm4_key_sched_rev: random reads and keys compared
// against a direct software model of the SM4 key expansion.

module tb_sm4_key_sched_rev;
    localparam logic [127:0] TV_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [2047:0] SBOX_TBL = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [4:0]   rd_idx;
    logic         dec;
    logic [31:0]  rk_out;
    logic         rk_valid;

    int           n_checks;
    int           n_errors;
    logic [31:0]  m_rk [32];
    logic [31:0]  last_out;

    sm4_key_sched_rev #(.WIDTH(32), .NROUND(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .dec        (dec),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX_TBL >> (8 * (255 - int'(x)));
        return t[7:0];
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(x[8*j +: 8]);
        return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] kk [36];
        logic [31:0] ck;
        kk[0] = mk[127:96] ^ 32'hA3B1BAC6;
        kk[1] = mk[95:64]  ^ 32'h56AA3350;
        kk[2] = mk[63:32]  ^ 32'h677D9197;
        kk[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            ck = 32'd0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
            kk[i+4] = kk[i] ^ t_prime(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
            m_rk[i] = kk[i+4];
        end
    endtask

    // Called just after the accept edge; issues random reads while expanding.
    task automatic wait_done(input string tag);
        int n;
        int seen;
        int early;
        n = 0; seen = 0; early = 0;
        check({tag, "_busy_at_accept"}, 32'(busy), 32'd1);
        check({tag, "_ready_at_accept"}, 32'(key_ready), 32'd0);
        while (busy && n < 40) begin
            rd_en  = 1'($urandom_range(0, 1));
            rd_idx = 5'($urandom);
            dec    = 1'($urandom);
            tick();
            n++;
            if (rk_valid) seen++;
            if (busy && (keys_valid || key_ready)) early++;
        end
        rd_en = 1'b0;
        key_valid = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd32);
        check({tag, "_reads_ignored"}, 32'(seen), 32'd0);
        check({tag, "_no_early_valid"}, 32'(early), 32'd0);
        check({tag, "_keys_valid"}, 32'(keys_valid), 32'd1);
        check({tag, "_key_ready"}, 32'(key_ready), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [4:0] idx, input logic d, input logic [31:0] exp);
        rd_en = 1'b1; rd_idx = idx; dec = d;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rk_valid), 32'd1);
        check({tag, "_data"}, rk_out, exp);
        last_out = exp;
    endtask

    task automatic stream(input string tag, input logic d);
        rd_en = 1'b1; dec = d;
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            tick();
            check({tag, "_valid"}, 32'(rk_valid), 32'd1);
            check({tag, "_data"}, rk_out, d ? m_rk[31 - i] : m_rk[i]);
        end
        last_out = d ? m_rk[0] : m_rk[31];
        rd_en = 1'b0;
        tick();
        check({tag, "_end_valid"}, 32'(rk_valid), 32'd0);
    endtask

    task automatic random_reads(input string tag, input int cycles);
        logic       en;
        logic [4:0] idx;
        logic       d;
        for (int c = 0; c < cycles; c++) begin
            en  = 1'($urandom_range(0, 2) != 0);
            idx = 5'($urandom);
            d   = 1'($urandom);
            rd_en = en; rd_idx = idx; dec = d;
            tick();
            if (en) last_out = d ? m_rk[31 - int'(idx)] : m_rk[idx];
            check({tag, "_valid"}, 32'(rk_valid), 32'(en));
            check({tag, "_data"}, rk_out, last_out);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  old5;
        logic [127:0] rkey;
        n_checks = 0; n_errors = 0; last_out = 32'd0;
        rst = 1'b1; key_valid = 1'b0; key = '0; rd_en = 1'b0; rd_idx = '0; dec = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_keys_valid", 32'(keys_valid), 32'd0);
        check("rst_rk_valid", 32'(rk_valid), 32'd0);
        check("rst_rk_out", rk_out, 32'd0);

        rd_en = 1'b1; rd_idx = 5'd3;
        tick();
        rd_en = 1'b0;
        check("idle_read_ignored", 32'(rk_valid), 32'd0);

        // Test-vector key; key_valid stays high with a different key during expansion.
        model_expand(TV_KEY);
        key = TV_KEY; key_valid = 1'b1;
        tick();
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_done("tv");
        check("tv_rk_out_held", rk_out, 32'd0);

        do_read("fwd0", 5'd0, 1'b0, 32'hF12186F9);
        do_read("fwd1", 5'd1, 1'b0, 32'h41662B61);
        do_read("fwd31", 5'd31, 1'b0, 32'h9124A012);
        tick();
        check("fwd_valid_drop", 32'(rk_valid), 32'd0);
        check("fwd_out_hold", rk_out, 32'h9124A012);
        do_read("dec0", 5'd0, 1'b1, 32'h9124A012);
        do_read("dec31", 5'd31, 1'b1, 32'hF12186F9);
        stream("tv_dec_stream", 1'b1);
        stream("tv_fwd_stream", 1'b0);
        random_reads("tv_rand", 40);

        // Reset at expansion cycle 10, then reload the same key.
        key = TV_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_keys_valid", 32'(keys_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_key_ready", 32'(key_ready), 32'd1);
        check("midrst_rk_out", rk_out, 32'd0);
        rd_en = 1'b1; rd_idx = 5'd0;
        tick();
        rd_en = 1'b0;
        check("midrst_read_ignored", 32'(rk_valid), 32'd0);
        key_valid = 1'b1;
        tick();
        wait_done("reload");
        do_read("reload_rk31", 5'd31, 1'b0, 32'h9124A012);
        do_read("reload_rk0", 5'd0, 1'b0, 32'hF12186F9);

        // Re-key on the same edge as a read: old rk5 comes out.
        old5 = m_rk[5];
        rd_en = 1'b1; rd_idx = 5'd5; dec = 1'b0;
        key = '0; key_valid = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rekey_read_valid", 32'(rk_valid), 32'd1);
        check("rekey_read_old", rk_out, old5);
        check("rekey_keys_valid", 32'(keys_valid), 32'd0);
        last_out = old5;
        model_expand(128'd0);
        wait_done("rekey");
        stream("zero_fwd_stream", 1'b0);

        for (int r = 0; r < 2; r++) begin
            rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(rkey);
            key = rkey; key_valid = 1'b1;
            tick();
            wait_done($sformatf("rkey%0d", r));
            random_reads($sformatf("rkey%0d_rand", r), 48);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
